// File: rtl/camera_capture_if.sv
// SPI register-interface bundle between the peripheral decoder (master) and
// the camera capture buffer (slave).
interface camera_capture_if;
  logic [7:0]  op_code_in;
  logic        op_code_valid_in;
  logic [7:0]  operand_in;
  logic        operand_valid_in;
  logic [31:0] operand_count_in;
  logic [7:0]  response_out;
  logic        response_valid_out;

  modport master (
    output op_code_in, op_code_valid_in, operand_in, operand_valid_in, operand_count_in,
    input  response_out, response_valid_out
  );

  modport slave (
    input  op_code_in, op_code_valid_in, operand_in, operand_valid_in, operand_count_in,
    output response_out, response_valid_out
  );
endinterface

// File: rtl/camera_capture.sv
// Camera capture frame buffer behind the SPI register interface: 0x20 capture,
// 0x21 bytes available, 0x22 read. Define CAMERA_CHECKSUM_EN to add 0x23 checksum.
module camera_capture #(
  parameter int CAPTURE_X_RESOLUTION = 200,
  parameter int CAPTURE_Y_RESOLUTION = 200
) (
  input  logic           clock_in,
  input  logic           reset_in,
  camera_capture_if.slave spi
);
  localparam int unsigned DEPTH    = CAPTURE_X_RESOLUTION * CAPTURE_Y_RESOLUTION;
  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [15:0] LAST_PTR = 16'(DEPTH - 1);

  localparam logic [7:0] OP_CAPTURE = 8'h20;
  localparam logic [7:0] OP_AVAIL   = 8'h21;
  localparam logic [7:0] OP_READ    = 8'h22;
  localparam logic [7:0] OP_CSUM    = 8'h23;

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] CAPTURING = 1'b1;

  logic [7:0]  mem [DEPTH];
  logic [0:0]  state;
  logic [15:0] write_ptr;
  logic [15:0] read_ptr;
  logic [15:0] avail_snap;
  logic [15:0] avail_now;
  logic        op_valid_q;
  logic        operand_valid_q;
  logic        start;
  logic        pulse;
  logic        empty;
  logic [7:0]  rd_byte;
`ifdef CAMERA_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  // Operand bytes carry no meaning for any opcode.
  logic unused_ok;
  assign unused_ok = ^spi.operand_in;

  assign start   = spi.op_code_valid_in & ~op_valid_q;
  assign pulse   = spi.operand_valid_in & ~operand_valid_q & spi.op_code_valid_in;
  assign empty   = (read_ptr == write_ptr);
  assign rd_byte = mem[read_ptr[AW-1:0]];

  // A pulse coinciding with the start edge sees the live count, not the stale snapshot.
  always_comb begin
    avail_now = avail_snap;
    if (start) avail_now = write_ptr - read_ptr;
  end

  // Pattern generator: pixel k holds k[7:0].
  always_ff @(posedge clock_in) begin
    if (state == CAPTURING) mem[write_ptr[AW-1:0]] <= write_ptr[7:0];
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state              <= IDLE;
      write_ptr          <= '0;
      read_ptr           <= '0;
      avail_snap         <= '0;
      op_valid_q         <= 1'b0;
      operand_valid_q    <= 1'b0;
      spi.response_out   <= '0;
      spi.response_valid_out <= 1'b0;
`ifdef CAMERA_CHECKSUM_EN
      checksum           <= '0;
`endif
    end else begin
      op_valid_q      <= spi.op_code_valid_in;
      operand_valid_q <= spi.operand_valid_in;

      if (state == CAPTURING) begin
        write_ptr <= write_ptr + 16'd1;
        if (write_ptr == LAST_PTR) state <= IDLE;
`ifdef CAMERA_CHECKSUM_EN
        checksum <= checksum + write_ptr[7:0];
`endif
      end

      if (start && spi.op_code_in == OP_CAPTURE && state != CAPTURING) begin
        write_ptr <= '0;
        read_ptr  <= '0;
        state     <= CAPTURING;
`ifdef CAMERA_CHECKSUM_EN
        checksum  <= '0;
`endif
      end

      if (start && spi.op_code_in == OP_AVAIL) avail_snap <= write_ptr - read_ptr;

      if (pulse) begin
        case (spi.op_code_in)
          OP_AVAIL: begin
            spi.response_valid_out <= 1'b1;
            if (spi.operand_count_in == 32'd0)      spi.response_out <= avail_now[15:8];
            else if (spi.operand_count_in == 32'd1) spi.response_out <= avail_now[7:0];
            else                                    spi.response_out <= '0;
          end
          OP_READ: begin
            spi.response_valid_out <= 1'b1;
            if (!empty) begin
              spi.response_out <= rd_byte;
              read_ptr         <= read_ptr + 16'd1;
            end else begin
              spi.response_out <= '0;
            end
          end
`ifdef CAMERA_CHECKSUM_EN
          OP_CSUM: begin
            spi.response_valid_out <= 1'b1;
            spi.response_out <= (spi.operand_count_in == 32'd0) ? checksum : 8'h00;
          end
`endif
          default: ;
        endcase
      end else if (!spi.operand_valid_in) begin
        spi.response_valid_out <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_camera_capture.sv
// Self-checking bench for camera_capture with a 5x5 frame; expected bytes come
// from a queue model of the frame buffer.
module tb_camera_capture;
  localparam int X = 5;
  localparam int Y = 5;
  localparam int N = X * Y;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [7:0] model_q[$];
  logic [7:0] model_csum = 8'h00;

  camera_capture_if bus();

  camera_capture #(
    .CAPTURE_X_RESOLUTION(X),
    .CAPTURE_Y_RESOLUTION(Y)
  ) dut (
    .clock_in(clk),
    .reset_in(rst),
    .spi(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic begin_op(input logic [7:0] op);
    @(posedge clk); #1;
    bus.op_code_in       = op;
    bus.op_code_valid_in = 1'b1;
    repeat ($urandom_range(1, 2)) @(posedge clk);
    #1;
  endtask

  task automatic end_op();
    bus.op_code_valid_in = 1'b0;
    bus.operand_count_in = '0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int cnt, input logic exp_valid, input logic [7:0] exp, input string tag);
    bus.operand_in       = 8'($urandom);
    bus.operand_count_in = 32'(cnt);
    bus.operand_valid_in = 1'b1;
    @(posedge clk); #1;
    check({tag, " valid"}, {7'b0, bus.response_valid_out}, {7'b0, exp_valid});
    if (exp_valid) check(tag, bus.response_out, exp);
    repeat ($urandom_range(1, 3)) @(posedge clk);
    #1;
    check({tag, " held valid"}, {7'b0, bus.response_valid_out}, {7'b0, exp_valid});
    if (exp_valid) check({tag, " held"}, bus.response_out, exp);
    bus.operand_valid_in = 1'b0;
    @(posedge clk); #1;
    check({tag, " drop"}, {7'b0, bus.response_valid_out}, 8'h00);
    repeat ($urandom_range(0, 2)) @(posedge clk);
    #1;
  endtask

  task automatic txn_capture(input string tag);
    begin_op(8'h20);
    pulse(0, 1'b0, 8'h00, {tag, " capture pulse"});
    end_op();
    model_q.delete();
    model_csum = 8'h00;
    for (int k = 0; k < N; k++) begin
      model_q.push_back(8'(k));
      model_csum = model_csum + 8'(k);
    end
    repeat (30) @(posedge clk);
    #1;
  endtask

  task automatic txn_avail(input int npulses, input string tag);
    logic [15:0] a;
    a = 16'(model_q.size());
    begin_op(8'h21);
    for (int i = 0; i < npulses; i++)
      pulse(i, 1'b1, (i == 0) ? a[15:8] : (i == 1) ? a[7:0] : 8'h00,
            $sformatf("%s avail[%0d]", tag, i));
    end_op();
  endtask

  task automatic txn_read(input int n, input string tag);
    logic [7:0] e;
    begin_op(8'h22);
    for (int i = 0; i < n; i++) begin
      e = (model_q.size() != 0) ? model_q.pop_front() : 8'h00;
      pulse(i, 1'b1, e, $sformatf("%s read[%0d]", tag, i));
    end
    end_op();
  endtask

  task automatic txn_silent(input logic [7:0] op, input string tag);
    begin_op(op);
    pulse(0, 1'b0, 8'h00, tag);
    end_op();
  endtask

  initial begin
    bus.op_code_in       = '0;
    bus.op_code_valid_in = 1'b0;
    bus.operand_in       = '0;
    bus.operand_valid_in = 1'b0;
    bus.operand_count_in = '0;

    repeat (5) @(posedge clk);
    #1;
    check("reset response", bus.response_out, 8'h00);
    check("reset valid", {7'b0, bus.response_valid_out}, 8'h00);
    rst = 1'b0;

    txn_avail(2, "s1");

    txn_capture("s2");
    txn_avail(3, "s2");

    txn_read(11, "s3");
    txn_avail(2, "s3");

    txn_read(10, "s4a");
    txn_read(4, "s4b");
    txn_avail(2, "s4");

    txn_read(1, "s5 empty");
    txn_avail(2, "s5");
    txn_silent(8'h55, "s5 unknown");

    txn_capture("s6");
`ifdef CAMERA_CHECKSUM_EN
    begin_op(8'h23);
    pulse(0, 1'b1, model_csum, "s6 checksum");
    pulse(1, 1'b1, 8'h00, "s6 checksum tail");
    end_op();
`else
    txn_silent(8'h23, "s6 no checksum");
`endif

    // Reset in the middle of a capture empties the buffer.
    begin_op(8'h20);
    end_op();
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_q.delete();
    txn_avail(2, "mid reset");

    txn_capture("rand");
    for (int it = 0; it < 6; it++) begin
      txn_read(int'($urandom_range(0, 9)), $sformatf("rand%0d", it));
      txn_avail(2, $sformatf("rand%0d", it));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
